// File: rtl/conv_pkg.sv
// Shared constants, sideband types and width helpers for the conv MAC array.
package conv_pkg;

    localparam int unsigned TAPS        = 9;
    localparam int unsigned CENTRE_TAP  = 4;
    localparam int unsigned PROD_W      = 18;
    localparam int unsigned LEAKY_SHIFT = 3;

    typedef struct packed {
        logic valid;
        logic last;
    } pipe_ctl_t;

    function automatic int unsigned tap_sum_w(input int unsigned cin_par);
        return PROD_W + $clog2(cin_par);
    endfunction

    function automatic int unsigned beat_sum_w(input int unsigned cin_par);
        return PROD_W + $clog2(TAPS * cin_par);
    endfunction

endpackage

// File: rtl/conv_mac_array_if.sv
// Beat-in / result-out bus of the conv MAC array; master drives beats, slave is the engine.
interface conv_mac_array_if #(
    parameter int unsigned CIN_PAR  = 8,
    parameter int unsigned COUT_PAR = 4,
    parameter int unsigned ACC_W    = 32
);
    import conv_pkg::*;

    logic                                mode_1x1;
    logic                                flush;
    logic                                in_valid;
    logic                                in_ready;
    logic                                in_last;
    logic [TAPS*CIN_PAR*8-1:0]           pixels;
    logic [COUT_PAR*TAPS*CIN_PAR*8-1:0]  weights;
    logic [COUT_PAR*32-1:0]              bias;
    logic [COUT_PAR*ACC_W-1:0]           out_data;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        output mode_1x1, flush, in_valid, in_last, pixels, weights, bias, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  mode_1x1, flush, in_valid, in_last, pixels, weights, bias, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/conv_dot_unit.sv
// One filter's S1-S3 datapath: per-channel products, per-tap sums, beat sum; advances on en_i.
module conv_dot_unit
    import conv_pkg::*;
#(
    parameter int unsigned CIN_PAR = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en_i,
    input  logic                                  mode_1x1_i,
    input  logic [TAPS*CIN_PAR*8-1:0]             pixels_i,
    input  logic [TAPS*CIN_PAR*8-1:0]             weights_i,
    output logic signed [beat_sum_w(CIN_PAR)-1:0] beat_sum_o
);

    localparam int unsigned TapW  = tap_sum_w(CIN_PAR);
    localparam int unsigned BeatW = beat_sum_w(CIN_PAR);

    logic signed [PROD_W-1:0] prod_d [TAPS][CIN_PAR];
    logic signed [PROD_W-1:0] prod_q [TAPS][CIN_PAR];
    logic signed [TapW-1:0]   tap_d  [TAPS];
    logic signed [TapW-1:0]   tap_q  [TAPS];
    logic signed [BeatW-1:0]  beat_d;
    logic signed [BeatW-1:0]  beat_q;

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    function automatic logic signed [PROD_W-1:0] mul8(input logic [7:0] pix,
                                                      input logic [7:0] wgt);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = PROD_W'(signed'({1'b0, pix}));
        b = PROD_W'(signed'(wgt));
        return a * b;
    endfunction

    always_comb begin
        prod_d = prod_q;
        if (en_i) begin
            for (int unsigned t = 0; t < TAPS; t++) begin
                for (int unsigned c = 0; c < CIN_PAR; c++) begin
                    prod_d[t][c] = mul8(
                        (mode_1x1_i && t != CENTRE_TAP) ? 8'h00 : pixels_i[(t*CIN_PAR+c)*8 +: 8],
                        (mode_1x1_i && t != CENTRE_TAP) ? 8'h00 : weights_i[(t*CIN_PAR+c)*8 +: 8]);
                end
            end
        end
    end

    always_comb begin
        tap_d = tap_q;
        if (en_i) begin
            for (int unsigned t = 0; t < TAPS; t++) begin
                tap_d[t] = '0;
                for (int unsigned c = 0; c < CIN_PAR; c++) begin
                    tap_d[t] = tap_d[t] + TapW'(prod_q[t][c]);
                end
            end
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (en_i) begin
            beat_d = '0;
            for (int unsigned t = 0; t < TAPS; t++) begin
                beat_d = beat_d + BeatW'(tap_q[t]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '{default: '0};
            tap_q  <= '{default: '0};
            beat_q <= '0;
        end else begin
            prod_q <= prod_d;
            tap_q  <= tap_d;
            beat_q <= beat_d;
        end
    end

    assign beat_sum_o = beat_q;

endmodule

// File: rtl/conv_mac_array.sv
// Parallel-filter 3x3/1x1 convolution MAC with valid/ready backpressure.
// Optional CONV_LEAKY_EN: leaky-ReLU (x>>>3 for negative x) on the emitted result.
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int unsigned CIN_PAR  = 8,
    parameter int unsigned COUT_PAR = 4,
    parameter int unsigned ACC_W    = 32
) (
    input logic             clk,
    input logic             rst,
    conv_mac_array_if.slave bus
);

    localparam int unsigned BeatW = beat_sum_w(CIN_PAR);
    localparam int unsigned PixW  = TAPS * CIN_PAR * 8;

    logic adv;
    logic accept;

    pipe_ctl_t              s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    logic [COUT_PAR*32-1:0] s1_bias_d, s1_bias_q, s2_bias_d, s2_bias_q, s3_bias_d, s3_bias_q;

    logic signed [BeatW-1:0] beat_sum [COUT_PAR];
    logic signed [ACC_W-1:0] acc_d    [COUT_PAR];
    logic signed [ACC_W-1:0] acc_q    [COUT_PAR];
    logic signed [ACC_W-1:0] part_sum [COUT_PAR];
    logic signed [ACC_W-1:0] full_sum [COUT_PAR];
    logic signed [ACC_W-1:0] result   [COUT_PAR];

    logic [COUT_PAR*ACC_W-1:0] out_data_d, out_data_q;
    logic                      out_valid_d, out_valid_q;

    // A held result freezes every stage, so nothing in flight can be overwritten.
    assign adv          = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && adv && !bus.flush;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    for (genvar f = 0; f < COUT_PAR; f++) begin : g_dot
        conv_dot_unit #(
            .CIN_PAR(CIN_PAR)
        ) u_dot (
            .clk       (clk),
            .rst       (rst),
            .en_i      (adv),
            .mode_1x1_i(bus.mode_1x1),
            .pixels_i  (bus.pixels),
            .weights_i (bus.weights[f*PixW +: PixW]),
            .beat_sum_o(beat_sum[f])
        );
    end

    always_comb begin
        s1_d      = s1_q;
        s2_d      = s2_q;
        s3_d      = s3_q;
        s1_bias_d = s1_bias_q;
        s2_bias_d = s2_bias_q;
        s3_bias_d = s3_bias_q;
        if (adv) begin
            s1_d.valid = accept;
            s1_d.last  = bus.in_last;
            s1_bias_d  = bus.bias;
            s2_d       = s1_q;
            s2_bias_d  = s1_bias_q;
            s3_d       = s2_q;
            s3_bias_d  = s2_bias_q;
        end
        if (bus.flush) begin
            s1_d.valid = 1'b0;
            s2_d.valid = 1'b0;
            s3_d.valid = 1'b0;
        end
    end

    always_comb begin
        for (int unsigned f = 0; f < COUT_PAR; f++) begin
            part_sum[f] = acc_q[f] + ACC_W'(beat_sum[f]);
            full_sum[f] = part_sum[f] + ACC_W'(signed'(s3_bias_q[f*32 +: 32]));
`ifdef CONV_LEAKY_EN
            result[f] = full_sum[f][ACC_W-1] ? (full_sum[f] >>> LEAKY_SHIFT) : full_sum[f];
`else
            result[f] = full_sum[f];
`endif
        end
    end

    // A flush also kills the beat sitting in S3 this cycle.
    always_comb begin
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        if (adv && s3_q.valid && !bus.flush) begin
            if (s3_q.last) begin
                out_valid_d = 1'b1;
                for (int unsigned f = 0; f < COUT_PAR; f++) begin
                    out_data_d[f*ACC_W +: ACC_W] = result[f];
                    acc_d[f]                     = '0;
                end
            end else begin
                for (int unsigned f = 0; f < COUT_PAR; f++) begin
                    acc_d[f] = part_sum[f];
                end
            end
        end
        if (bus.flush) begin
            acc_d = '{default: '0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            s1_bias_q   <= '0;
            s2_bias_q   <= '0;
            s3_bias_q   <= '0;
            acc_q       <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            s1_bias_q   <= s1_bias_d;
            s2_bias_q   <= s2_bias_d;
            s3_bias_q   <= s3_bias_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
